// File: rtl/mm_burst_read_to_host.sv
// mm_burst_read_to_host
// Reads a block of PSRAM words on behalf of the host. A read command gives a
// word address and a word count. The block splits the command into RAM read
// bursts of at most BURST_LEN words. Returned words are buffered in an
// internal first-word-fall-through FIFO. The buffered words are offered to the
// QSPI read shifter as a valid/ready stream.
//
// Ports
//   xClk, reset_n           : clock, asynchronous active-low reset
//   xRamReady               : RAM usable; no burst is requested while low
//   xCmdValid/xCmdReady     : host command handshake (ready only when idle)
//   xCmdAddr, xCmdLen       : start word address, word count (0 is legal)
//   xGbReqRead              : RAM read request, held until the burst-done cycle
//   xGbAddress, xBurstLength: burst start address and length
//   xStreamValid/Data       : RAM read data
//   xWrBurstDone            : RAM burst-done pulse
//   xRdData/Valid/Ready     : output word stream (head of FIFO)
//   xBusy                   : command in progress or FIFO holds data
//   xOvfErr, xLenErr        : sticky overflow / burst-length errors
//   xErrClr                 : clears both sticky errors
module mm_burst_read_to_host #(
  parameter int BURST_LEN  = 256,
  parameter int FIFO_DEPTH = 1024,
  parameter int ADDR_W     = 23
) (
  input  logic              xClk,
  input  logic              reset_n,
  input  logic              xRamReady,
  input  logic              xCmdValid,
  output logic              xCmdReady,
  input  logic [ADDR_W-1:0] xCmdAddr,
  input  logic [15:0]       xCmdLen,
  output logic              xGbReqRead,
  output logic [ADDR_W-1:0] xGbAddress,
  output logic [10:0]       xBurstLength,
  input  logic              xStreamValid,
  input  logic [15:0]       xStreamData,
  input  logic              xWrBurstDone,
  output logic [15:0]       xRdData,
  output logic              xRdValid,
  input  logic              xRdReady,
  output logic              xBusy,
  output logic              xOvfErr,
  output logic              xLenErr,
  input  logic              xErrClr
);

  localparam int PW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, CHECK, REQ, DATA} state_t;

  state_t            state;
  logic [ADDR_W-1:0] curAddr;
  logic [15:0]       remWords;
  logic [10:0]       wordCnt;

  logic [15:0]       fifoMem [FIFO_DEPTH];
  logic [PW:0]       wrPtr;
  logic [PW:0]       rdPtr;
  logic [PW:0]       occupancy;
  logic [PW:0]       freeSpace;
  logic              fifoFull;

  logic              inBurst;
  logic              capEn;
  logic              pushEn;
  logic              popEn;
  logic              ovfEvt;
  logic              lenEvt;
  logic [10:0]       chunkCalc;
  logic [10:0]       cntNext;
  logic              canIssue;

  // Extra pointer bit distinguishes full from empty. A pop in the same cycle
  // frees a slot, so a push at full is still accepted.
  always_comb begin
    occupancy = wrPtr - rdPtr;
    fifoFull  = occupancy[PW];
    freeSpace = (PW+1)'(FIFO_DEPTH) - occupancy;
    inBurst   = (state == REQ) || (state == DATA);
    capEn     = inBurst && xStreamValid;
    popEn     = (occupancy != '0) && xRdReady;
    pushEn    = capEn && (!fifoFull || popEn);
    ovfEvt    = capEn && fifoFull && !popEn;
    cntNext   = wordCnt + {10'd0, capEn};
    lenEvt    = inBurst && xWrBurstDone && (cntNext != xBurstLength);
    chunkCalc = (remWords >= 16'(BURST_LEN)) ? 11'(BURST_LEN) : remWords[10:0];
    canIssue  = xRamReady && (17'(freeSpace) >= 17'(chunkCalc));
  end

  assign xRdData   = fifoMem[rdPtr[PW-1:0]];
  assign xRdValid  = (occupancy != '0);
  assign xCmdReady = (state == IDLE);
  assign xBusy     = (state != IDLE) || (occupancy != '0);

  // FIFO storage has no reset; the pointers alone define its contents.
  always_ff @(posedge xClk) begin
    if (pushEn) fifoMem[wrPtr[PW-1:0]] <= xStreamData;
  end

  // FIFO pointers.
  always_ff @(posedge xClk or negedge reset_n) begin
    if (!reset_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (pushEn) wrPtr <= wrPtr + 1'b1;
      if (popEn)  rdPtr <= rdPtr + 1'b1;
    end
  end

  // Command FSM: latch command, wait for RAM and FIFO room, issue burst,
  // count returned words, advance to the next chunk on burst done.
  always_ff @(posedge xClk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      curAddr      <= '0;
      remWords     <= '0;
      wordCnt      <= '0;
      xGbReqRead   <= 1'b0;
      xGbAddress   <= '0;
      xBurstLength <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (xCmdValid) begin
            curAddr  <= xCmdAddr;
            remWords <= xCmdLen;
            if (xCmdLen != 16'd0) state <= CHECK;
          end
        end
        CHECK: begin
          if (canIssue) begin
            xGbAddress   <= curAddr;
            xBurstLength <= chunkCalc;
            xGbReqRead   <= 1'b1;
            wordCnt      <= '0;
            state        <= REQ;
          end
        end
        REQ, DATA: begin
          if (capEn) wordCnt <= cntNext;
          if (xWrBurstDone) begin
            xGbReqRead <= 1'b0;
            curAddr    <= curAddr + ADDR_W'(xBurstLength);
            remWords   <= remWords - 16'(xBurstLength);
            wordCnt    <= '0;
            state      <= (remWords == 16'(xBurstLength)) ? IDLE : CHECK;
          end else if (state == REQ) begin
            state <= DATA;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Sticky errors; a new error event beats a clear in the same cycle.
  always_ff @(posedge xClk or negedge reset_n) begin
    if (!reset_n) begin
      xOvfErr <= 1'b0;
      xLenErr <= 1'b0;
    end else begin
      if (ovfEvt)       xOvfErr <= 1'b1;
      else if (xErrClr) xOvfErr <= 1'b0;
      if (lenEvt)       xLenErr <= 1'b1;
      else if (xErrClr) xLenErr <= 1'b0;
    end
  end

endmodule

// File: doc/mm_burst_read_to_host.md
Name: mm_burst_read_to_host

Overview:
- Reader counterpart to the QSPI-fed write path (mm_burst_write). It accepts a host read command (word address, word count) in the xClk domain.
- It splits the command into PSRAM read bursts on one MultiPortRamCtrl port and buffers the returned words in an internal FIFO.
- Words are presented to the host-side serializer (QSPI read shifter) as a valid/ready stream.
- It lets the MCU read back PSRAM contents, e.g. for OSD or framebuffer inspection and BIST diagnostics.

Parameters:
- BURST_LEN, 256, maximum words per RAM burst request; must be 1..1024.
- FIFO_DEPTH, 1024, data FIFO depth in 16-bit words; power of two, must be >= BURST_LEN.
- ADDR_W, 23, RAM word-address width.

Ports:
- xClk  in  1  system clock; all logic is in this domain.
- reset_n  in  1  asynchronous active-low reset.
- xRamReady  in  1  RAM usable (BIST finished); no request is issued while low.
- xCmdValid  in  1  host read command valid.
- xCmdReady  out  1  block idle and can accept a command.
- xCmdAddr  in  ADDR_W  start word address.
- xCmdLen  in  16  number of words to read; 0 is legal.
- xGbReqRead  out  1  RAM port read request.
- xGbAddress  out  ADDR_W  RAM burst start address.
- xBurstLength  out  11  length of the current burst.
- xStreamValid  in  1  RAM read data valid (dout_valid).
- xStreamData  in  16  RAM read data.
- xWrBurstDone  in  1  RAM burst done pulse.
- xRdData  out  16  output stream data (head of FIFO, first-word-fall-through).
- xRdValid  out  1  output word available.
- xRdReady  in  1  consumer accepts word.
- xBusy  out  1  command in progress or FIFO non-empty.
- xOvfErr  out  1  sticky: a word was dropped because the FIFO was full.
- xLenErr  out  1  sticky: word count at done did not equal xBurstLength.
- xErrClr  in  1  clears both sticky errors.

Behaviour:
- Reset (async assert, sync release) gives:
  - xCmdReady=1, xGbReqRead=0, xGbAddress=0, xBurstLength=0;
  - xRdValid=0, xBusy=0, errors=0;
  - FIFO empty, FSM in IDLE.
- FSM states: IDLE, CHECK, REQ, DATA.
- IDLE:
  - xCmdReady=1.
  - On xCmdValid&xCmdReady, latch addr and remaining count (rem=xCmdLen).
  - If xCmdLen=0: stay in IDLE, no request issued. Otherwise go to CHECK.
  - xCmdReady=0 in every state except IDLE.
- CHECK:
  - chunk = min(rem, BURST_LEN).
  - Go to REQ only when xRamReady=1 and FIFO free space >= chunk, where free = FIFO_DEPTH - occupancy.
  - Otherwise wait; the consumer draining the FIFO eventually satisfies the condition.
- REQ:
  - Drive xGbAddress=addr and xBurstLength=chunk, assert xGbReqRead.
  - Hold all three stable until the xWrBurstDone cycle; deassert xGbReqRead the following cycle.
  - Go to DATA as soon as the request is asserted. Data capture is active in both REQ and DATA.
- Capture:
  - Every xStreamValid cycle writes xStreamData into the FIFO and increments the burst word counter.
  - If the FIFO is full, the word is dropped and xOvfErr is set.
- On xWrBurstDone:
  - If counter != chunk (including valid coincident with done), set xLenErr.
  - addr += chunk, wrapping modulo 2^ADDR_W. rem -= chunk. Counter cleared.
  - If rem=0 go to IDLE, else go to CHECK.
- Stream output:
  - xRdValid = FIFO non-empty.
  - Pop on xRdValid&xRdReady; xRdData is updated the next cycle.
  - Simultaneous push and pop leaves occupancy unchanged, including at full: a pop frees the slot in the same cycle, so no drop and no error.
  - Empty FIFO with a push: xRdValid rises the cycle after the push.
- Latency: command to xGbReqRead is 2 cycles minimum (IDLE->CHECK->REQ).
- xBusy = (state != IDLE) | FIFO non-empty.
- xErrClr: clears the sticky errors. If an error event occurs in the same cycle, the set wins.
- xRamReady falling in CHECK stalls the FSM. A request already issued is not withdrawn.
- Reset mid-burst:
  - Everything returns to reset values and the FIFO is flushed.
  - Late xStreamValid or xWrBurstDone arriving in IDLE is ignored; it is not written and sets no flag.

Test Plan:
- Cmd addr=0x000100, len=256, BURST_LEN=256 -> one request: xGbAddress=0x000100, xBurstLength=256. 256 words arrive in order, xRdValid drops after the 256th pop, xCmdReady returns to 1.
- Cmd len=600 -> bursts at addr A, A+256, A+512 with lengths 256, 256, 88. Output is exactly 600 words.
- Consumer holds xRdReady=0 with FIFO_DEPTH=1024, cmd len=2048 -> 4 bursts issued, 5th held in CHECK. After 256 pops the 5th request issues. No xOvfErr.
- Cmd len=0 -> no xGbReqRead, xCmdReady stays 1, xBusy stays 0.
- Model returns 255 words then done for chunk=256 -> xLenErr=1. xErrClr clears it. Next command proceeds normally.
- Cmd addr=0x7FFF80, len=256, BURST_LEN=128 -> second burst address 0x000000. Plus: reset_n pulsed low mid-DATA -> outputs at reset values, FIFO empty, subsequent stray xStreamValid ignored.
